// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus arbiter: FSM states, requester source ids,
// and the default ack timeout.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] ID_SHA  = 2'b01;
  localparam logic [1:0] ID_IDX1 = 2'b00;
  localparam logic [1:0] ID_CTRL = 2'b11;
  localparam logic [1:0] ID_NONE = 2'b10;

  localparam int ARB_TIMEOUT_DEFAULT = 16;

  // Requester index to the source id driven on grant_id.
  function automatic logic [1:0] src_id(input int idx);
    case (idx)
      0:       src_id = ID_SHA;
      1:       src_id = ID_IDX1;
      2:       src_id = ID_CTRL;
      default: src_id = ID_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request found after last_idx,
// wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_idx,
  output logic [NREQ-1:0] pick_oh,
  output logic            pick_vld
);

  int idx;

  always_comb begin
    pick_oh  = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_idx) + off) % NREQ;
      if (!pick_vld && req[idx]) begin
        pick_oh[idx] = 1'b1;
        pick_vld     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared data bus with a registered one-hot grant.
// Define ARB_TIMEOUT_EN to force a release when ack does not arrive within TIMEOUT cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            bus_valid,
  input  logic            ack,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_id,
  output logic            busy,
  output logic            timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [1:0]      grant_id_nxt;
  logic [IW-1:0]   last_idx, last_idx_nxt;
  logic [IW-1:0]   pick_idx, cur_idx;
  logic [NREQ-1:0] pick_oh;
  logic            pick_vld;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req      (req),
    .last_idx (last_idx),
    .pick_oh  (pick_oh),
    .pick_vld (pick_vld)
  );

  // One-hot to index for both the fresh pick and the current holder.
  always_comb begin
    pick_idx = '0;
    cur_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_idx = IW'(i);
      if (grant[i])   cur_idx  = IW'(i);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             terr_nxt;
  assign cnt_inc = cnt + 1'b1;
`endif

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    last_idx_nxt = last_idx;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt      = cnt;
    terr_nxt     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt    = ST_GRANT;
          grant_nxt    = pick_oh;
          grant_id_nxt = src_id(int'(pick_idx));
        end
      end
      ST_GRANT: begin
        if (bus_valid) begin
          state_nxt = ST_WAIT_ACK;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end else if ((req & grant) == '0) begin
          // Grantee withdrew before using the bus: pointer stays put.
          state_nxt    = ST_IDLE;
          grant_nxt    = '0;
          grant_id_nxt = ID_NONE;
        end
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          state_nxt    = ST_RELEASE;
          grant_nxt    = '0;
          grant_id_nxt = ID_NONE;
          last_idx_nxt = cur_idx;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_nxt    = ST_RELEASE;
          grant_nxt    = '0;
          grant_id_nxt = ID_NONE;
          last_idx_nxt = cur_idx;
          terr_nxt     = 1'b1;
          cnt_nxt      = cnt_inc;
        end else begin
          cnt_nxt = cnt_inc;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_id <= ID_NONE;
      last_idx <= IW'(NREQ - 1);
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      last_idx <= last_idx_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      timeout_err <= terr_nxt;
    end
  end
`else
  // No watchdog in this build; the expression is constant false.
  assign timeout_err = (TIMEOUT < 0);
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; covers both ARB_TIMEOUT_EN builds.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       bus_valid;
  logic       ack;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter #(.NREQ(3), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .bus_valid   (bus_valid),
    .ack         (ack),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_exp [4];
  logic       terr_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    rst_n = 1'b0; req = '0; bus_valid = 1'b0; ack = 1'b0;
    cyc(); cyc();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_id", 32'(grant_id), 32'h2);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);

    // req 101: index 0 first, then index 2 after release.
    rst_n = 1'b1; req = 3'b101;
    cyc();
    chk("g0_grant", 32'(grant), 32'h1);
    chk("g0_id", 32'(grant_id), 32'h1);
    chk("g0_busy", 32'(busy), 32'h1);
    bus_valid = 1'b1; cyc(); bus_valid = 1'b0;
    chk("g0_hold", 32'(grant), 32'h1);
    ack = 1'b1; req = 3'b100; cyc(); ack = 1'b0;
    chk("g0_rel_grant", 32'(grant), 32'h0);
    chk("g0_rel_id", 32'(grant_id), 32'h2);
    chk("g0_rel_busy", 32'(busy), 32'h1);
    cyc();
    chk("idle_busy", 32'(busy), 32'h0);
    cyc();
    chk("g2_grant", 32'(grant), 32'h4);
    chk("g2_id", 32'(grant_id), 32'h3);
    bus_valid = 1'b1; cyc(); bus_valid = 1'b0;
    ack = 1'b1; req = 3'b000; cyc(); ack = 1'b0;
    cyc();

    // All requesting: rotation 0,1,2,0 with zero grant between holders.
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(rr_exp[k]));
      bus_valid = 1'b1; cyc(); bus_valid = 1'b0;
      cyc();
      chk($sformatf("rr%0d_hold", k), 32'(grant), 32'(rr_exp[k]));
      ack = 1'b1;
      if (k == 3) req = 3'b000;
      cyc(); ack = 1'b0;
      chk($sformatf("rr%0d_rel", k), 32'(grant), 32'h0);
      cyc();
      chk($sformatf("rr%0d_idle", k), 32'(grant), 32'h0);
    end

    // Grantee withdraws in GRANT: pointer unchanged, same index wins again.
    req = 3'b010; cyc();
    chk("wd_grant", 32'(grant), 32'h2);
    req = 3'b000; cyc();
    chk("wd_drop_grant", 32'(grant), 32'h0);
    chk("wd_drop_busy", 32'(busy), 32'h0);
    req = 3'b111; cyc();
    chk("wd_regrant", 32'(grant), 32'h2);
    chk("wd_regrant_id", 32'(grant_id), 32'h0);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("ack_in_grant", 32'(grant), 32'h2);
    chk("ack_in_grant_busy", 32'(busy), 32'h1);

    // No ack after bus_valid.
    bus_valid = 1'b1; cyc(); bus_valid = 1'b0;
    terr_seen = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      cyc();
      terr_seen = terr_seen | timeout_err;
    end
    chk("to_before_grant", 32'(grant), 32'h2);
    chk("to_before_terr", 32'(terr_seen), 32'h0);
    cyc();
    chk("to_pulse", 32'(timeout_err), 32'h1);
    chk("to_grant_clr", 32'(grant), 32'h0);
    cyc();
    chk("to_pulse_end", 32'(timeout_err), 32'h0);
`else
    for (int k = 0; k < 100; k++) begin
      cyc();
      terr_seen = terr_seen | timeout_err;
    end
    chk("noto_grant", 32'(grant), 32'h2);
    chk("noto_terr", 32'(terr_seen), 32'h0);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("noto_rel", 32'(grant), 32'h0);
    cyc();
`endif

    // Reset in WAIT_ACK drops the grant and rewinds the pointer.
    cyc();
    chk("pre_rst_grant", 32'(grant), 32'h4);
    bus_valid = 1'b1; cyc(); bus_valid = 1'b0;
    rst_n = 1'b0; cyc();
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_id", 32'(grant_id), 32'h2);
    chk("mid_rst_terr", 32'(timeout_err), 32'h0);
    rst_n = 1'b1; cyc();
    chk("post_rst_grant", 32'(grant), 32'h1);

    // Ack on the 16th WAIT_ACK cycle: normal release.
    bus_valid = 1'b1; cyc(); bus_valid = 1'b0;
    terr_seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      terr_seen = terr_seen | timeout_err;
    end
    chk("ack16_hold", 32'(grant), 32'h1);
    ack = 1'b1; req = 3'b000; cyc(); ack = 1'b0;
    terr_seen = terr_seen | timeout_err;
    chk("ack16_rel", 32'(grant), 32'h0);
    cyc();
    terr_seen = terr_seen | timeout_err;
    chk("ack16_terr", 32'(terr_seen), 32'h0);
    chk("ack16_idle", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
